// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: per-frame paddle/ball sequencer with wall, paddle and brick collisions, score and lives
module breakout_game_ctrl #(
  parameter int BALL_SIZE   = 7,
  parameter int PADDLE_W    = 100,
  parameter int PADDLE_Y    = 440,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_SPEED  = 2,
  parameter int START_LIVES = 3,
  parameter int BRICK_X0    = 40,
  parameter int BRICK_Y0    = 40
) (
  input  logic       CLK_25MH,
  input  logic       reset,
  input  logic [9:0] hor_count,
  input  logic [9:0] ver_count,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       launch,
  output logic [9:0] paddle_pos,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       active_write_enable,
  output logic [5:0] active_position,
  output logic [1:0] active_data,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       win
);
  typedef enum logic [3:0] {CLEAR, SERVE, WAIT_TICK, MOVE, WALL, PAD, BRICK, COMMIT, LOST, WON} state_t;
  localparam logic signed [10:0] SPD  = 11'(BALL_SPEED);
  localparam logic signed [10:0] XMAX = 11'(639 - BALL_SIZE);
  localparam logic signed [10:0] YMAX = 11'sd480;
  localparam logic [10:0] BS      = 11'(BALL_SIZE);
  localparam logic [10:0] PY1     = 11'(PADDLE_Y + 1);
  localparam logic [10:0] PY9     = 11'(PADDLE_Y + 9);
  localparam logic [10:0] PW1     = 11'(PADDLE_W - 1);
  localparam logic [10:0] BW      = 11'd80;
  localparam logic [10:0] BH      = 11'd30;
  localparam logic [10:0] PITCH   = 11'd120;
  localparam logic [9:0]  PMAX    = 10'(640 - PADDLE_W);
  localparam logic [9:0]  PSTEP   = 10'(PADDLE_STEP);
  localparam logic [9:0]  SERVE_Y = 10'(PADDLE_Y - BALL_SIZE - 1);
  localparam logic [9:0]  SERVE_X = 10'(PADDLE_W / 2 - (BALL_SIZE + 1) / 2);
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [9:0] paddle_q, paddle_d, ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic signed [10:0] nx_q, nx_d, ny_q, ny_d, bx0, by0;
  logic dx_q, dx_d, dy_q, dy_d;
  logic [9:0][1:0] shadow_q, shadow_d;
  logic we_q, we_d, go_q, go_d, win_q, win_d;
  logic [5:0] pos_q, pos_d;
  logic [1:0] data_q, data_d, lives_q, lives_d, ns;
  logic [7:0] score_q, score_d;
  logic tick, brick_row, pad_hit, brick_hit;
  logic [3:0] col;
  logic [10:0] nxu, nyu, bx, by, pad_l;
  logic [9:0] pad_upd;
  assign tick = hor_count == 10'd0 && ver_count == 10'd480;
  assign nxu = nx_q;
  assign nyu = ny_q;
  assign bx0 = $signed({1'b0, ball_x_q});
  assign by0 = $signed({1'b0, ball_y_q});
  assign pad_l = {1'b0, paddle_q};
  assign pad_upd = (btn_left && !btn_right) ? (paddle_q >= PSTEP ? paddle_q - PSTEP : 10'd0) :
                   (btn_right && !btn_left) ? (paddle_q + PSTEP > PMAX ? PMAX : paddle_q + PSTEP) : paddle_q;
  assign brick_row = idx_q >= 4'd5;
  assign col = brick_row ? idx_q - 4'd5 : idx_q;
  assign bx = 11'(BRICK_X0) + {7'd0, col} * PITCH;
  assign by = brick_row ? 11'(BRICK_Y0 + 50) : 11'(BRICK_Y0);
  assign ns = shadow_q[idx_q] + 2'd1;
  assign pad_hit = dy_q && nyu + BS >= PY1 && nyu + BS <= PY9 && nxu <= pad_l + PW1 && nxu + BS >= pad_l + 11'd1;
  assign brick_hit = shadow_q[idx_q] != 2'b11 && nxu <= bx + BW && nxu + BS >= bx && nyu <= by + BH && nyu + BS >= by;
  // next-state and datapath for the frame sequencer
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    paddle_d = paddle_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    nx_d = nx_q;
    ny_d = ny_q;
    dx_d = dx_q;
    dy_d = dy_q;
    shadow_d = shadow_q;
    we_d = 1'b0;
    pos_d = pos_q;
    data_d = data_q;
    score_d = score_q;
    lives_d = lives_q;
    case (state_q)
      CLEAR: begin
        we_d = 1'b1;
        pos_d = {2'b00, idx_q};
        data_d = 2'b00;
        shadow_d[idx_q] = 2'b00;
        idx_d = idx_q == 4'd9 ? 4'd0 : idx_q + 4'd1;
        state_d = idx_q == 4'd9 ? SERVE : CLEAR;
      end
      SERVE: begin
        paddle_d = tick ? pad_upd : paddle_q;
        ball_x_d = paddle_d + SERVE_X;
        ball_y_d = SERVE_Y;
        if (tick && launch) begin
          dx_d = 1'b1;
          dy_d = 1'b0;
          state_d = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        paddle_d = tick ? pad_upd : paddle_q;
        state_d = tick ? MOVE : WAIT_TICK;
      end
      MOVE: begin
        nx_d = dx_q ? bx0 + SPD : bx0 - SPD;
        ny_d = dy_q ? by0 + SPD : by0 - SPD;
        state_d = WALL;
      end
      WALL: begin
        if (nx_q <= 11'sd0) begin
          nx_d = 11'sd0;
          dx_d = 1'b1;
        end else if (nx_q >= XMAX) begin
          nx_d = XMAX;
          dx_d = 1'b0;
        end
        if (ny_q >= YMAX) begin
          lives_d = lives_q - 2'd1;
          state_d = lives_q == 2'd1 ? LOST : SERVE;
        end else begin
          if (ny_q <= 11'sd0) begin
            ny_d = 11'sd0;
            dy_d = 1'b1;
          end
          state_d = PAD;
        end
      end
      PAD: begin
        if (pad_hit) begin
          dy_d = 1'b0;
          ny_d = $signed({1'b0, SERVE_Y});
        end
        idx_d = 4'd0;
        state_d = BRICK;
      end
      BRICK: begin
        if (brick_hit) begin
          dy_d = ~dy_q;
          shadow_d[idx_q] = ns;
          we_d = 1'b1;
          pos_d = {2'b00, idx_q};
          data_d = ns;
          score_d = (ns == 2'b11 && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + 4'd1;
          state_d = idx_q == 4'd9 ? COMMIT : BRICK;
        end
      end
      COMMIT: begin
        ball_x_d = nxu[9:0];
        ball_y_d = nyu[9:0];
        idx_d = 4'd0;
        state_d = &shadow_q ? WON : WAIT_TICK;
      end
      LOST, WON: begin
        if (launch) begin
          score_d = 8'd0;
          lives_d = 2'(START_LIVES);
          idx_d = 4'd0;
          state_d = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
    go_d = state_d == LOST || state_d == WON;
    win_d = state_d == WON;
  end
  // register all state and outputs
  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q <= 4'd0;
      paddle_q <= 10'd270;
      ball_x_q <= 10'd316;
      ball_y_q <= 10'd432;
      nx_q <= 11'sd0;
      ny_q <= 11'sd0;
      dx_q <= 1'b1;
      dy_q <= 1'b0;
      shadow_q <= '0;
      we_q <= 1'b0;
      pos_q <= 6'd0;
      data_q <= 2'd0;
      score_q <= 8'd0;
      lives_q <= 2'(START_LIVES);
      go_q <= 1'b0;
      win_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      paddle_q <= paddle_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      nx_q <= nx_d;
      ny_q <= ny_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      shadow_q <= shadow_d;
      we_q <= we_d;
      pos_q <= pos_d;
      data_q <= data_d;
      score_q <= score_d;
      lives_q <= lives_d;
      go_q <= go_d;
      win_q <= win_d;
    end
  end
  assign paddle_pos = paddle_q;
  assign ball_x = ball_x_q;
  assign ball_y = ball_y_q;
  assign active_write_enable = we_q;
  assign active_position = pos_q;
  assign active_data = data_q;
  assign score = score_q;
  assign lives = lives_q;
  assign game_over = go_q;
  assign win = win_q;
endmodule
